fetch_stage: RTL and testbench

Instruction-fetch stage of the M0 pipeline: owns the program counter and the IF/ID pipeline register. It drives the enable and byte address of the combinational instruction ROM, captures the returned big-endian instruction word, and hands {pc, inst, valid, adel} to decode. It applies stall, branch redirect (with delay-slot semantics) and exception flush, and records misaligned fetches as address-error exceptions.

---
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, deferred-branch register and the
// IF/ID pipeline register. Drives a combinational ROM and hands the fetched
// word to decode together with its PC and an address-error flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        flush,
  input  logic [31:0] exc_pc,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;

  logic        mis;
  logic [31:0] fw;
  logic        stall_pc;

  assign mis      = (pc_q[1:0] != 2'b00);
  assign fw       = mis ? 32'h0 : rom_inst;
  // A held IF/ID register must also hold the PC, otherwise an instruction is lost.
  assign stall_pc = stall_if | stall_id;

  assign rom_en   = ce_q & ~mis;
  assign rom_addr = pc_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign id_adel  = id_adel_q;

  // PC and deferred-branch next state; the PC only moves once fetch is enabled.
  always_comb begin
    pc_d      = pc_q;
    ce_d      = 1'b1;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    if (ce_q) begin
      if (flush) begin
        pc_d     = exc_pc;
        pend_v_d = 1'b0;
      end else if (stall_pc) begin
        // Remember a branch resolved while stalled; the delay slot still sits in IF.
        if (branch_en) begin
          pend_v_d  = 1'b1;
          pend_pc_d = branch_target;
        end
      end else if (branch_en) begin
        pc_d     = branch_target;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        pc_d     = pend_pc_q;
        pend_v_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // IF/ID register next state: flush clears, stall_id freezes, stall_if bubbles.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (flush) begin
      id_pc_d    = 32'h0;
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else if (stall_id) begin
      id_pc_d = id_pc_q;
    end else if (stall_if) begin
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
      id_adel_d  = 1'b0;
    end else begin
      id_pc_d    = pc_q;
      id_inst_d  = fw;
      id_valid_d = ce_q;
      id_adel_d  = ce_q & mis;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= 32'h0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      id_adel_q  <= id_adel_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, a redirect-level reference model
// compared on every falling edge, and literal expectations at key points.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush, branch_en;
  logic [31:0] exc_pc, branch_target;
  logic        rom_en;
  logic [31:0] rom_addr, rom_inst;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, id_adel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
    .exc_pc(exc_pc), .branch_en(branch_en), .branch_target(branch_target),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_adel(id_adel)
  );

  // ROM contents: 0x11111111, 0x22222222, ... in the first 64 bytes, upper bits mixed in.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [3:0] nib;
    nib = 4'(a[5:2] + 4'd1);
    return {8{nib}} ^ {a[31:6], 6'b0};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where fetch is, which redirect is owed, and what sits in ID.
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_owed;
  logic [31:0] m_owed_to;
  logic [31:0] m_id_pc, m_id_inst;
  logic        m_id_valid, m_id_adel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_started <= 1'b0; m_owed <= 1'b0; m_owed_to <= 32'h0;
      m_id_pc <= 32'h0; m_id_inst <= 32'h0; m_id_valid <= 1'b0; m_id_adel <= 1'b0;
    end else begin
      // What decode receives this edge.
      if (flush) begin
        m_id_pc <= 32'h0; m_id_inst <= 32'h0; m_id_valid <= 1'b0; m_id_adel <= 1'b0;
      end else if (!stall_id) begin
        if (stall_if) begin
          m_id_inst <= 32'h0; m_id_valid <= 1'b0; m_id_adel <= 1'b0;
        end else begin
          m_id_pc    <= m_pc;
          m_id_inst  <= (m_pc % 4 != 0) ? 32'h0 : rom_word(m_pc);
          m_id_valid <= m_started;
          m_id_adel  <= m_started && (m_pc % 4 != 0);
        end
      end
      // Where fetch goes next.
      m_started <= 1'b1;
      if (m_started) begin
        if (flush) begin
          m_pc <= exc_pc; m_owed <= 1'b0;
        end else if (stall_if || stall_id) begin
          if (branch_en) begin m_owed <= 1'b1; m_owed_to <= branch_target; end
        end else if (branch_en) begin
          m_pc <= branch_target; m_owed <= 1'b0;
        end else if (m_owed) begin
          m_pc <= m_owed_to; m_owed <= 1'b0;
        end else begin
          m_pc <= 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
      end
    end
  end

  // Compare process: outputs depend only on state, so the falling edge is stable.
  always @(negedge clk) begin
    check("m_rom_en",   {31'b0, rom_en},   {31'b0, m_started && (m_pc % 4 == 0)});
    check("m_rom_addr", rom_addr,          m_pc);
    check("m_id_pc",    id_pc,             m_id_pc);
    check("m_id_inst",  id_inst,           m_id_inst);
    check("m_id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    check("m_id_adel",  {31'b0, id_adel},  {31'b0, m_id_adel});
  end

  // Apply one cycle of inputs at the falling edge and wait through the next rising edge.
  task automatic cyc(input logic si, input logic sd, input logic fl, input logic [31:0] epc,
                     input logic be, input logic [31:0] bt);
    stall_if = si; stall_id = sd; flush = fl; exc_pc = epc; branch_en = be; branch_target = bt;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0; branch_en = 1'b0;
    exc_pc = 32'h0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_rom_en", {31'b0, rom_en}, 32'd0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    rst = 1'b0;

    // Startup and sequential fetch.
    idle();
    check("start_rom_en", {31'b0, rom_en}, 32'd1);
    check("start_id_valid", {31'b0, id_valid}, 32'd0);
    idle();
    check("seq0_pc", id_pc, 32'h0);
    check("seq0_inst", id_inst, 32'h1111_1111);
    check("seq0_valid", {31'b0, id_valid}, 32'd1);
    idle();
    check("seq1_pc", id_pc, 32'h4);
    check("seq1_inst", id_inst, 32'h2222_2222);

    // Branch to 0x40 while PC=0x8: 0x8 is the delay slot.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    check("br_slot_pc", id_pc, 32'h8);
    check("br_slot_inst", id_inst, 32'h3333_3333);
    check("br_addr", rom_addr, 32'h40);
    idle();
    check("br_tgt_pc", id_pc, 32'h40);
    check("br_tgt_inst", id_inst, 32'h1111_1151);
    idle();
    check("br_next_pc", id_pc, 32'h44);

    // stall_if for two cycles: PC held, two bubbles.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("sif1_valid", {31'b0, id_valid}, 32'd0);
    check("sif1_addr", rom_addr, 32'h48);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("sif2_valid", {31'b0, id_valid}, 32'd0);
    check("sif2_pc_hold", id_pc, 32'h44);
    idle();
    check("sif_resume_pc", id_pc, 32'h48);

    // stall_id freezes ID; a branch during it is deferred.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("sid_pc", id_pc, 32'h48);
    check("sid_valid", {31'b0, id_valid}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
    check("sid_br_addr", rom_addr, 32'h4C);
    idle();
    check("pend_slot_pc", id_pc, 32'h4C);
    check("pend_addr", rom_addr, 32'h80);
    idle();
    check("pend_tgt_pc", id_pc, 32'h80);

    // Flush beats branch, stall and a pending branch.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    cyc(1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 32'h200);
    check("fl_addr", rom_addr, 32'h180);
    check("fl_id_valid", {31'b0, id_valid}, 32'd0);
    check("fl_id_pc", id_pc, 32'h0);
    idle();
    check("fl_next_addr", rom_addr, 32'h184);
    check("fl_id_pc2", id_pc, 32'h180);

    // New branch beats an older deferred one.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600);
    check("newbr_addr", rom_addr, 32'h600);
    idle();
    check("newbr_next", rom_addr, 32'h604);

    // Misaligned target.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
    check("mis_rom_en", {31'b0, rom_en}, 32'd0);
    idle();
    check("mis_id_pc", id_pc, 32'h42);
    check("mis_id_inst", id_inst, 32'h0);
    check("mis_id_adel", {31'b0, id_adel}, 32'd1);
    check("mis_addr_next", rom_addr, 32'h46);

    // Wrap at the top of the address space.
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    idle();
    check("wrap_top", rom_addr, 32'hFFFF_FFFC);
    idle();
    check("wrap_zero", rom_addr, 32'h0);

    // Asynchronous reset between edges, with a deferred branch outstanding.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h700);
    stall_id = 1'b0; branch_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_rom_en", {31'b0, rom_en}, 32'd0);
    check("arst_rom_addr", rom_addr, 32'h0);
    check("arst_id_pc", id_pc, 32'h0);
    check("arst_id_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    idle();
    check("arst_lost_pend", rom_addr, 32'h4);
    check("arst_first_pc", id_pc, 32'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
